// File: rtl/seq_pkg.sv
// Shared types and constants for the RV32I stage sequencer.
package seq_pkg;

  typedef enum logic [7:0] {
    S_BOOT   = 8'b0000_0001,
    S_FETCH  = 8'b0000_0010,
    S_DECODE = 8'b0000_0100,
    S_EXEC   = 8'b0000_1000,
    S_MEM    = 8'b0001_0000,
    S_WRITE  = 8'b0010_0000,
    S_HALT   = 8'b0100_0000,
    S_ERR    = 8'b1000_0000
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_IMEM_TO  = 2'b01;
  localparam logic [1:0] ERR_DMEM_TO  = 2'b10;
  localparam logic [1:0] ERR_MISALIGN = 2'b11;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_8000;

  // The wait counter only has to hold TIMEOUT-1 before it trips.
  function automatic int timer_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Handshake wait counter shared by the FETCH and MEM states.
module seq_wait_timer
  import seq_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int W = timer_width(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  // One more unacknowledged cycle would make the wait reach TIMEOUT.
  assign expired = (count == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// Central one-hot FSM walking one RV32I instruction through its stages.
// Optional performance counters are built when SEQ_PERF_EN is defined.
module stage_sequencer
  import seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_req,
  input  logic        mem_op,
  input  logic [31:0] pc_next,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        exec_en,
  output logic        mem_en,
  output logic        write_en,
  output logic [31:0] pc,
  output logic        halted,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] err_code_nxt;
  logic       pc_load;
  logic       waiting;
  logic       wait_ack;
  logic       expired;

  assign waiting  = (state == S_FETCH) || (state == S_MEM);
  assign wait_ack = (state == S_FETCH) ? imem_ack : dmem_ack;

  seq_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!waiting),
    .en      (waiting && !wait_ack),
    .expired (expired)
  );

  always_comb begin
    state_nxt    = state;
    err_code_nxt = err_code;
    pc_load      = 1'b0;
    case (state)
      S_BOOT:   state_nxt = S_FETCH;
      S_FETCH: begin
        // An ack on the expiry cycle still takes priority over the timeout.
        if (imem_ack) begin
          state_nxt = S_DECODE;
        end else if (expired) begin
          state_nxt    = S_ERR;
          err_code_nxt = ERR_IMEM_TO;
        end
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = mem_op ? S_MEM : S_WRITE;
      S_MEM: begin
        if (dmem_ack) begin
          state_nxt = S_WRITE;
        end else if (expired) begin
          state_nxt    = S_ERR;
          err_code_nxt = ERR_DMEM_TO;
        end
      end
      S_WRITE: begin
        if (pc_next[1:0] != 2'b00) begin
          state_nxt    = S_ERR;
          err_code_nxt = ERR_MISALIGN;
        end else begin
          pc_load   = 1'b1;
          state_nxt = halt_req ? S_HALT : S_FETCH;
        end
      end
      S_HALT:   if (!halt_req) state_nxt = S_FETCH;
      S_ERR:    state_nxt = S_ERR;
      default:  state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_BOOT;
      pc       <= RESET_PC;
      err_code <= ERR_NONE;
    end else begin
      state    <= state_nxt;
      err_code <= err_code_nxt;
      if (pc_load) pc <= pc_next;
    end
  end

  assign fetch_en  = (state == S_FETCH);
  assign decode_en = (state == S_DECODE);
  assign exec_en   = (state == S_EXEC);
  assign mem_en    = (state == S_MEM);
  assign write_en  = (state == S_WRITE);
  assign imem_req  = (state == S_FETCH);
  assign dmem_req  = (state == S_MEM);
  assign halted    = (state == S_HALT);
  assign err       = (state == S_ERR);

`ifdef SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if ((state != S_BOOT) && (state != S_ERR)) cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_load) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule
